// File: rtl/ir_prefetch_queue_if.sv
// Bus-side and decoder-side signals of the instruction prefetch queue.
// Handshakes:
//   load: the word on bus is accepted at a rising edge when busEn=1, busReady=1 and flush=0.
//         busEn while busReady=0 drops the word and sets the sticky overflow flag.
//   take: the head word is consumed at a rising edge when instrTake=1, instrValid=1 and flush=0.
//         instruction stays stable while instrTake=0.
//   Both responses (busReady, instrValid, instruction, count) come from registered state only.
interface ir_prefetch_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] bus;
  logic             busEn;
  logic             busReady;
  logic             flush;
  logic [WIDTH-1:0] instruction;
  logic             instrValid;
  logic             instrTake;
  logic [CW-1:0]    count;
  logic             overflow;

  // Memory bus plus decoder side (drives loads, takes and flushes)
  modport master (
    output bus, busEn, flush, instrTake,
    input  busReady, instruction, instrValid, count, overflow
  );

  // The queue itself
  modport slave (
    input  bus, busEn, flush, instrTake,
    output busReady, instruction, instrValid, count, overflow
  );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction register with a small prefetch FIFO. Words are loaded from the
// memory bus and presented head-first to the decoder; flush supports branch
// redirects. Full/empty are resolved by the occupancy counter, not pointers.
module ir_prefetch_queue #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_INSTR = '0
) (
  input  logic              clk,
  input  logic              resetN,
  ir_prefetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             ready;
  logic             valid;
  logic             load;
  logic             take;

  // Status derived from the counter only, so no input reaches an output
  always_comb begin
    ready = (cnt != CW'(DEPTH));
    valid = (cnt != '0);
    load  = q.busEn & ready & ~q.flush;
    take  = q.instrTake & valid & ~q.flush;
  end

  // Storage is not reset; entries past the head are don't-care
  always_ff @(posedge clk) begin
    if (load) mem[wr_ptr] <= q.bus;
  end

  // Pointers, occupancy and sticky overflow; flush wins over load/take
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (load) wr_ptr <= wr_ptr + PW'(1);
      if (take) rd_ptr <= rd_ptr + PW'(1);
      case ({load, take})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (q.busEn && !ready) ovf <= 1'b1;
    end
  end

  // Head word, or the NOP encoding when nothing is queued
  always_comb begin
    q.busReady    = ready;
    q.instrValid  = valid;
    q.count       = cnt;
    q.overflow    = ovf;
    q.instruction = valid ? mem[rd_ptr] : RESET_INSTR;
  end
endmodule
